// File: rtl/arm_pkg.sv
// Shared constants for the ARM flag register and condition evaluation:
// condition-field encodings and {N,Z,C,V} bit positions.
package arm_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned COND_W  = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-field evaluation against {N,Z,C,V}.
// Shared with the branch unit, so it carries no state.
module arm_cond_eval
  import arm_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_status_flags.sv
// CPSR condition flags downstream of the ALU: S-bit capture, MSR writes,
// carry feedback and condition evaluation. Define ARM_SPSR_EN for SPSR save/restore.
module arm_status_flags
  import arm_pkg::*;
#(
  parameter bit FLAG_BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  input  logic               s_bit,
  input  logic               logic_op,
  input  logic               alu_n,
  input  logic               alu_z,
  input  logic               alu_c,
  input  logic               alu_v,
  input  logic               shifter_c,
  input  logic               msr_we,
  input  logic [FLAGS_W-1:0] msr_data,
  input  logic               exc_entry,
  input  logic               exc_return,
  input  logic [COND_W-1:0]  cond,
  output logic [FLAGS_W-1:0] flags,
  output logic               c_out,
  output logic               cond_pass
);

  logic [FLAGS_W-1:0] flags_next;
  logic [FLAGS_W-1:0] eval_flags;

`ifdef ARM_SPSR_EN
  logic [FLAGS_W-1:0] spsr;
  logic               spsr_we;
`else
  logic unused_exc;
  assign unused_exc = exc_entry ^ exc_return;
`endif

  // One update source per cycle; ALU inputs are only looked at when qualified.
  always_comb begin
    flags_next = flags;
`ifdef ARM_SPSR_EN
    spsr_we    = 1'b0;
    if (exc_return) begin
      flags_next = spsr;
    end else if (exc_entry) begin
      spsr_we = 1'b1;
    end else
`endif
    if (msr_we) begin
      flags_next = msr_data;
    end else if (alu_valid && s_bit) begin
      if (logic_op) begin
        flags_next = {alu_n, alu_z, shifter_c, flags[FLAG_V]};
      end else begin
        flags_next = {alu_n, alu_z, alu_c, alu_v};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else begin
      flags <= flags_next;
    end
  end

`ifdef ARM_SPSR_EN
  // SPSR captures the pre-update flags on exception entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spsr <= '0;
    end else if (spsr_we) begin
      spsr <= flags;
    end
  end
`endif

  assign eval_flags = FLAG_BYPASS ? flags_next : flags;
  assign c_out      = eval_flags[FLAG_C];

  arm_cond_eval u_cond_eval (
    .cond  (cond),
    .flags (eval_flags),
    .pass  (cond_pass)
  );

endmodule

// File: tb/tb_arm_status_flags.sv
// Scoreboard bench for arm_status_flags: one bypassed and one registered instance
// share stimulus; expectations are queued per cycle and checked by a monitor.
module tb_arm_status_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_valid, s_bit, logic_op;
  logic       alu_n, alu_z, alu_c, alu_v, shifter_c;
  logic       msr_we;
  logic [3:0] msr_data;
  logic       exc_entry, exc_return;
  logic [3:0] cond;

  logic [3:0] flags_b, flags_r;
  logic       c_out_b, c_out_r;
  logic       pass_b, pass_r;

  typedef struct packed {
    logic [3:0] flags;
    logic       pass_b;
    logic       pass_r;
    logic       c_b;
    logic       c_r;
  } exp_t;

  exp_t       q[$];
  logic [3:0] cur;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  arm_status_flags u_dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .s_bit(s_bit), .logic_op(logic_op),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .shifter_c(shifter_c),
    .msr_we(msr_we), .msr_data(msr_data), .exc_entry(exc_entry), .exc_return(exc_return),
    .cond(cond), .flags(flags_b), .c_out(c_out_b), .cond_pass(pass_b)
  );

  arm_status_flags #(.FLAG_BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .s_bit(s_bit), .logic_op(logic_op),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .shifter_c(shifter_c),
    .msr_we(msr_we), .msr_data(msr_data), .exc_entry(exc_entry), .exc_return(exc_return),
    .cond(cond), .flags(flags_r), .c_out(c_out_r), .cond_pass(pass_r)
  );

  function automatic logic cmodel(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle_time=%0t got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Monitor: combinational outputs settle half a cycle after the inputs change.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("flags_bypass", flags_b, e.flags);
      chk("flags_reg", flags_r, e.flags);
      chk("cond_pass_bypass", {3'b0, pass_b}, {3'b0, e.pass_b});
      chk("cond_pass_reg", {3'b0, pass_r}, {3'b0, e.pass_r});
      chk("c_out_bypass", {3'b0, c_out_b}, {3'b0, e.c_b});
      chk("c_out_reg", {3'b0, c_out_r}, {3'b0, e.c_r});
    end
  end

  task automatic vec(input logic msr, input logic [3:0] md, input logic av, input logic sb,
                     input logic lo, input logic [3:0] af, input logic sc, input logic ee,
                     input logic er, input logic [3:0] cnd, input logic [3:0] nxt);
    exp_t e;
    msr_we = msr; msr_data = md; alu_valid = av; s_bit = sb; logic_op = lo;
    {alu_n, alu_z, alu_c, alu_v} = af; shifter_c = sc;
    exc_entry = ee; exc_return = er; cond = cnd;
    e.flags  = cur;
    e.pass_b = cmodel(cnd, nxt);
    e.pass_r = cmodel(cnd, cur);
    e.c_b    = nxt[1];
    e.c_r    = cur[1];
    q.push_back(e);
    @(posedge clk);
    #1;
    cur = nxt;
  endtask

  task automatic idle(input logic [3:0] cnd);
    vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, cnd, cur);
  endtask

  task automatic msr(input logic [3:0] d);
    vec(1'b1, d, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hE, d);
  endtask

  initial begin
    rst_n = 1'b0; cur = 4'h0;
    msr_we = 0; msr_data = 0; alu_valid = 0; s_bit = 0; logic_op = 0;
    {alu_n, alu_z, alu_c, alu_v} = 4'h0; shifter_c = 0;
    exc_entry = 0; exc_return = 0; cond = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    idle(4'h0);                 // held in reset: zero flags, EQ fails
    rst_n = 1'b1;

    // ALU set N,C,V; then asynchronous reset mid-run clears flags
    vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 4'hA, 4'b1011);
    idle(4'hA);
    rst_n = 1'b0;
    cur = 4'h0;
    idle(4'h1);
    rst_n = 1'b1;

    // Logical op keeps V, takes C from the shifter
    msr(4'b0001);
    vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0111);
    idle(4'h6);

    // Unqualified ALU inputs (even X) must not touch state
    vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'bxxxx, 1'bx, 1'b0, 1'b0, 4'h0, 4'b0111);
    vec(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'bxxxx, 1'bx, 1'b0, 1'b0, 4'h2, 4'b0111);

    // Bypass: same-cycle Z update seen by EQ; carry feedback
    msr(4'b0000);
    vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0100);
    idle(4'h0);
    vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'h2, 4'b0010);
    idle(4'h3);

    // MSR beats ALU
    vec(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0100);
    idle(4'h0);

    // Exception save / restore
    msr(4'b1010);
`ifdef ARM_SPSR_EN
    vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1010);
    msr(4'b0000);
    vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h8, 4'b1010);
    msr(4'b0011);
    vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hC, 4'b1010);
    msr(4'b0110);
    vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hB, 4'b1010);
`else
    vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0101);
    msr(4'b0000);
    vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h8, 4'b0000);
    msr(4'b0011);
    vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hC, 4'b0011);
    msr(4'b0110);
    vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hB, 4'b0110);
`endif
    idle(4'h0);

    // Full condition sweep over every flag value
    for (int f = 0; f < 16; f++) begin
      msr(4'(f));
      for (int c = 0; c < 16; c++) idle(4'(c));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
